// File: rtl/mem_responder.sv
// Wait-stated big-endian byte-addressed RAM answering the MOV/MOC 4-phase handshake.
// Define MEM_ALIGN_CHECK_EN to flag misaligned halfword/word accesses on err instead of force-aligning them.
module mem_responder #(
  parameter int ADDR_W      = 9,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MOV,
  input  logic        RW,
  input  logic [31:0] address,
  input  logic [1:0]  data_type,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        MOC,
  output logic        err
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state, state_nxt;
  logic [3:0]        cnt, cnt_nxt;
  logic              capture, commit;
  logic [ADDR_W-1:0] addr_p0;
  logic              rw_p0;
  logic [1:0]        dtype_p0;
  logic [31:0]       wdata_p0;
  logic [ADDR_W-1:0] a0, a1, a2, a3;
  logic              mis;
  logic [31:0]       rdata;
  logic [7:0]        mem [DEPTH];
  logic              unused_addr;

  assign unused_addr = &{1'b0, address[31:ADDR_W]};

  function automatic logic [ADDR_W-1:0] force_align(input logic [ADDR_W-1:0] a,
                                                    input logic [1:0] dt);
    logic [ADDR_W-1:0] r;
    r = a;
    if (dt == 2'b01) r[0] = 1'b0;
    else if (dt[1])  r[1:0] = 2'b00;
    return r;
  endfunction

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    capture   = 1'b0;
    commit    = 1'b0;
    case (state)
      IDLE: if (MOV) begin
        state_nxt = BUSY;
        cnt_nxt   = 4'(WAIT_CYCLES);
        capture   = 1'b1;
      end
      BUSY: begin
        if (!MOV) begin
          state_nxt = IDLE;
        end else if (cnt == 4'd0) begin
          state_nxt = DONE;
          commit    = !reset;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      DONE: if (!MOV) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Capture stage: request fields frozen for the whole transaction.
  always_ff @(posedge clk) begin
    if (capture) begin
      addr_p0  <= address[ADDR_W-1:0];
      rw_p0    <= RW;
      dtype_p0 <= data_type;
      wdata_p0 <= data_in;
    end
  end

`ifdef MEM_ALIGN_CHECK_EN
  assign mis = (dtype_p0 == 2'b01 && addr_p0[0]) ||
               (dtype_p0[1] && addr_p0[1:0] != 2'b00);
  assign a0  = addr_p0;
`else
  assign mis = 1'b0;
  assign a0  = force_align(addr_p0, dtype_p0);
`endif

  // Multi-byte accesses wrap naturally at the top of the ADDR_W-bit space.
  assign a1 = a0 + ADDR_W'(1);
  assign a2 = a0 + ADDR_W'(2);
  assign a3 = a0 + ADDR_W'(3);

  always_comb begin
    rdata = '0;
    case (dtype_p0)
      2'b00:   rdata = {24'd0, mem[a0]};
      2'b01:   rdata = {16'd0, mem[a0], mem[a1]};
      default: rdata = {mem[a0], mem[a1], mem[a2], mem[a3]};
    endcase
  end

  // Commit stage: RAM write / read on the BUSY -> DONE edge.
  always_ff @(posedge clk) begin
    if (commit && !rw_p0 && !mis) begin
      case (dtype_p0)
        2'b00: mem[a0] <= wdata_p0[7:0];
        2'b01: begin
          mem[a0] <= wdata_p0[15:8];
          mem[a1] <= wdata_p0[7:0];
        end
        default: begin
          mem[a0] <= wdata_p0[31:24];
          mem[a1] <= wdata_p0[23:16];
          mem[a2] <= wdata_p0[15:8];
          mem[a3] <= wdata_p0[7:0];
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      MOC      <= 1'b0;
      data_out <= '0;
    end else begin
      MOC <= (state_nxt == DONE);
      if (commit) begin
        if (mis)        data_out <= '0;
        else if (rw_p0) data_out <= rdata;
      end
    end
  end

`ifdef MEM_ALIGN_CHECK_EN
  always_ff @(posedge clk) begin
    if (reset)                  err <= 1'b0;
    else if (state_nxt != DONE) err <= 1'b0;
    else if (commit)            err <= mis;
  end
`else
  assign err = 1'b0;
`endif

endmodule
